// File: rtl/wb_trap_ctrl_pkg.sv
// Shared constants and types for the writeback trap/commit sequencer:
// datapath widths, exception cause codes, CSR addresses and FSM states.
package wb_trap_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_WIDTH = 32;

    localparam logic [31:0] CAUSE_IF_MISALIGN = 32'd0;
    localparam logic [31:0] CAUSE_IF_BUS_ERR  = 32'd1;
    localparam logic [31:0] CAUSE_ILGL        = 32'd2;
    localparam logic [31:0] CAUSE_BRK         = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP_JUMP = 2'd1,
        MRET_JUMP = 2'd2
    } state_e;

    typedef enum logic {
        MTVAL_ZERO = 1'b0,
        MTVAL_PC   = 1'b1
    } mtval_sel_e;

    // Word-align an address by clearing its two low bits.
    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_trap_ctrl_if.sv
// Writeback-stage, CSR-write and pipeline-control signals of the trap sequencer.
// The pipeline side uses master; the sequencer itself uses slave.
interface wb_trap_ctrl_if;
    import wb_trap_ctrl_pkg::*;

    logic                wb_valid_i;
    logic [PC_WIDTH-1:0] wb_pc_i;
    logic                wb_if_excp_misalign_i;
    logic                wb_if_excp_bus_err_i;
    logic                wb_id_excp_ilegl_instr_i;
    logic                wb_id_excp_ecall_i;
    logic                wb_id_excp_ebreak_i;
    logic                wb_id_excp_mret_i;
    logic [XLEN-1:0]     mtvec_i;
    logic                csr_wr_en_i;
    logic [11:0]         csr_wr_addr_i;
    logic [XLEN-1:0]     csr_wr_data_i;

    logic                rf_wr_kill_o;
    logic                flush_o;
    logic                stall_o;
    logic                redirect_en_o;
    logic [PC_WIDTH-1:0] redirect_pc_o;
    logic [PC_WIDTH-1:0] mepc_o;
    logic [XLEN-1:0]     mcause_o;
    logic [XLEN-1:0]     mtval_o;
    logic                mstatus_mie_o;
    logic                mstatus_mpie_o;

    modport slave (
        input  wb_valid_i, wb_pc_i, wb_if_excp_misalign_i, wb_if_excp_bus_err_i,
               wb_id_excp_ilegl_instr_i, wb_id_excp_ecall_i, wb_id_excp_ebreak_i,
               wb_id_excp_mret_i, mtvec_i, csr_wr_en_i, csr_wr_addr_i, csr_wr_data_i,
        output rf_wr_kill_o, flush_o, stall_o, redirect_en_o, redirect_pc_o,
               mepc_o, mcause_o, mtval_o, mstatus_mie_o, mstatus_mpie_o
    );

    modport master (
        output wb_valid_i, wb_pc_i, wb_if_excp_misalign_i, wb_if_excp_bus_err_i,
               wb_id_excp_ilegl_instr_i, wb_id_excp_ecall_i, wb_id_excp_ebreak_i,
               wb_id_excp_mret_i, mtvec_i, csr_wr_en_i, csr_wr_addr_i, csr_wr_data_i,
        input  rf_wr_kill_o, flush_o, stall_o, redirect_en_o, redirect_pc_o,
               mepc_o, mcause_o, mtval_o, mstatus_mie_o, mstatus_mpie_o
    );

endinterface

// File: rtl/wb_trap_ctrl_trap_prio_enc.sv
// Fixed-priority encoder over the WB exception flags: picks the single
// highest-priority event and reports its cause code and mtval source.
module trap_prio_enc
    import wb_trap_ctrl_pkg::*;
#(
    parameter int unsigned TRAP_CAUSE_W = 4
) (
    input  logic                    valid_i,
    input  logic                    if_misalign_i,
    input  logic                    if_bus_err_i,
    input  logic                    ilegl_instr_i,
    input  logic                    ecall_i,
    input  logic                    ebreak_i,
    input  logic                    mret_i,
    output logic                    trap_vld_o,
    output logic                    is_mret_o,
    output logic [TRAP_CAUSE_W-1:0] cause_o,
    output mtval_sel_e              mtval_sel_o
);

    // NOTE: every output gets a default before the if-chain so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        trap_vld_o  = valid_i & (if_misalign_i | if_bus_err_i | ilegl_instr_i |
                                 ecall_i | ebreak_i | mret_i);
        is_mret_o   = 1'b0;
        cause_o     = '0;
        mtval_sel_o = MTVAL_ZERO;

        if (if_misalign_i) begin
            cause_o     = CAUSE_IF_MISALIGN[TRAP_CAUSE_W-1:0];
            mtval_sel_o = MTVAL_PC;
        end else if (if_bus_err_i) begin
            cause_o     = CAUSE_IF_BUS_ERR[TRAP_CAUSE_W-1:0];
            mtval_sel_o = MTVAL_PC;
        end else if (ilegl_instr_i) begin
            cause_o = CAUSE_ILGL[TRAP_CAUSE_W-1:0];
        end else if (ebreak_i) begin
            cause_o = CAUSE_BRK[TRAP_CAUSE_W-1:0];
        end else if (ecall_i) begin
            cause_o = CAUSE_ECALL_M[TRAP_CAUSE_W-1:0];
        end else if (mret_i) begin
            is_mret_o = 1'b1;
        end
    end

endmodule

// File: rtl/wb_trap_ctrl.sv
// Writeback trap/commit sequencer: kills faulting writes, flushes the pipe,
// updates the machine trap CSRs and redirects fetch to mtvec or mepc.
module wb_trap_ctrl
    import wb_trap_ctrl_pkg::*;
#(
    parameter int unsigned TRAP_CAUSE_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    wb_trap_ctrl_if.slave  bus
);

    logic                    trap_vld;
    logic                    is_mret;
    logic [TRAP_CAUSE_W-1:0] trap_cause;
    mtval_sel_e              mtval_sel;

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     mepc_q, mepc_d;
    logic [TRAP_CAUSE_W-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0]         mtval_q, mtval_d;
    logic                    mie_q, mie_d;
    logic                    mpie_q, mpie_d;
    logic                    redirect_en_q, redirect_en_d;
    logic [PC_WIDTH-1:0]     redirect_pc_q, redirect_pc_d;

    trap_prio_enc #(.TRAP_CAUSE_W(TRAP_CAUSE_W)) u_prio_enc (
        .valid_i       (bus.wb_valid_i),
        .if_misalign_i (bus.wb_if_excp_misalign_i),
        .if_bus_err_i  (bus.wb_if_excp_bus_err_i),
        .ilegl_instr_i (bus.wb_id_excp_ilegl_instr_i),
        .ecall_i       (bus.wb_id_excp_ecall_i),
        .ebreak_i      (bus.wb_id_excp_ebreak_i),
        .mret_i        (bus.wb_id_excp_mret_i),
        .trap_vld_o    (trap_vld),
        .is_mret_o     (is_mret),
        .cause_o       (trap_cause),
        .mtval_sel_o   (mtval_sel)
    );

    always_comb begin
        state_d          = state_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        redirect_en_d    = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        bus.rf_wr_kill_o = 1'b0;
        bus.flush_o      = 1'b0;
        bus.stall_o      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trap_vld) begin
                    bus.rf_wr_kill_o = 1'b1;
                    bus.flush_o      = 1'b1;
                    bus.stall_o      = 1'b1;
                    redirect_en_d    = 1'b1;
                    if (is_mret) begin
                        // mepc as committed before this cycle is the return target.
                        redirect_pc_d = mepc_q;
                        mie_d         = mpie_q;
                        mpie_d        = 1'b1;
                        state_d       = MRET_JUMP;
                    end else begin
                        redirect_pc_d = word_align(bus.mtvec_i[PC_WIDTH-1:0]);
                        mepc_d        = word_align(bus.wb_pc_i);
                        mcause_d      = trap_cause;
                        mtval_d       = (mtval_sel == MTVAL_PC) ? XLEN'(bus.wb_pc_i) : '0;
                        mpie_d        = mie_q;
                        mie_d         = 1'b0;
                        state_d       = TRAP_JUMP;
                    end
                end else if (bus.csr_wr_en_i) begin
                    // A triggering trap above takes precedence; the write is then dropped.
                    unique case (bus.csr_wr_addr_i)
                        CSR_MSTATUS: begin
                            mie_d  = bus.csr_wr_data_i[MSTATUS_MIE_BIT];
                            mpie_d = bus.csr_wr_data_i[MSTATUS_MPIE_BIT];
                        end
                        CSR_MEPC:   mepc_d   = word_align(bus.csr_wr_data_i[PC_WIDTH-1:0]);
                        CSR_MCAUSE: mcause_d = bus.csr_wr_data_i[TRAP_CAUSE_W-1:0];
                        CSR_MTVAL:  mtval_d  = bus.csr_wr_data_i;
                        default: ;
                    endcase
                end
            end
            TRAP_JUMP, MRET_JUMP: begin
                bus.flush_o = 1'b1;
                bus.stall_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            redirect_en_q <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            redirect_en_q <= redirect_en_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // A reset landing in the jump cycle must not let the redirect escape.
    assign bus.redirect_en_o  = redirect_en_q & ~rst;
    assign bus.redirect_pc_o  = redirect_pc_q;
    assign bus.mepc_o         = mepc_q;
    assign bus.mcause_o       = {{(XLEN-TRAP_CAUSE_W){1'b0}}, mcause_q};
    assign bus.mtval_o        = mtval_q;
    assign bus.mstatus_mie_o  = mie_q;
    assign bus.mstatus_mpie_o = mpie_q;

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Self-checking bench for wb_trap_ctrl: a reference model pushes expected
// redirect/CSR results at trigger time, popped when the redirect pulse appears.
module tb_wb_trap_ctrl;
    import wb_trap_ctrl_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic        mie;
        logic        mpie;
    } exp_t;

    // Flag vector order used throughout the bench.
    localparam logic [5:0] F_MISALIGN = 6'b100000;
    localparam logic [5:0] F_BUS_ERR  = 6'b010000;
    localparam logic [5:0] F_ILGL     = 6'b001000;
    localparam logic [5:0] F_EBREAK   = 6'b000100;
    localparam logic [5:0] F_ECALL    = 6'b000010;
    localparam logic [5:0] F_MRET     = 6'b000001;
    localparam logic [31:0] MTVEC     = 32'h8000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    logic [31:0] m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;

    wb_trap_ctrl_if bus ();

    wb_trap_ctrl #(.TRAP_CAUSE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic drive_wb(input logic valid, input logic [5:0] f, input logic [31:0] pc);
        bus.wb_valid_i               = valid;
        bus.wb_pc_i                  = pc;
        bus.wb_if_excp_misalign_i    = f[5];
        bus.wb_if_excp_bus_err_i     = f[4];
        bus.wb_id_excp_ilegl_instr_i = f[3];
        bus.wb_id_excp_ebreak_i      = f[2];
        bus.wb_id_excp_ecall_i       = f[1];
        bus.wb_id_excp_mret_i        = f[0];
    endtask

    task automatic model_reset();
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mie = 0; m_mpie = 0;
    endtask

    task automatic model_csr(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h341: m_mepc   = {d[31:2], 2'b00};
            12'h342: m_mcause = {28'd0, d[3:0]};
            12'h343: m_mtval  = d;
            default: ;
        endcase
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.csr_wr_en_i = 1'b1; bus.csr_wr_addr_i = a; bus.csr_wr_data_i = d;
        @(posedge clk); #1;
        bus.csr_wr_en_i = 1'b0;
        model_csr(a, d);
    endtask

    // Drive one trapping instruction (optionally with a concurrent CSR write),
    // check the trigger cycle, then pop and compare at the redirect cycle.
    task automatic fire(input string name, input logic [5:0] f, input logic [31:0] pc,
                        input logic cw_en = 1'b0, input logic [11:0] cw_a = 12'h0,
                        input logic [31:0] cw_d = 32'h0);
        exp_t e;
        @(posedge clk); #1;
        drive_wb(1'b1, f, pc);
        bus.csr_wr_en_i = cw_en; bus.csr_wr_addr_i = cw_a; bus.csr_wr_data_i = cw_d;
        if (f[5] || f[4] || f[3] || f[2] || f[1]) begin
            m_mcause = f[5] ? 32'd0 : f[4] ? 32'd1 : f[3] ? 32'd2 : f[2] ? 32'd3 : 32'd11;
            m_mtval  = (f[5] || f[4]) ? pc : 32'd0;
            m_mepc   = {pc[31:2], 2'b00};
            m_mpie   = m_mie;
            m_mie    = 1'b0;
            e.pc     = {MTVEC[31:2], 2'b00};
        end else begin
            e.pc     = m_mepc;
            m_mie    = m_mpie;
            m_mpie   = 1'b1;
        end
        e.mepc = m_mepc; e.mcause = m_mcause; e.mtval = m_mtval;
        e.mie = m_mie; e.mpie = m_mpie;
        sb.push_back(e);
        @(negedge clk);
        total_cnt++;
        if ({bus.rf_wr_kill_o, bus.flush_o, bus.stall_o, bus.redirect_en_o} !== 4'b1110)
            $display("FAIL %s trigger kill/flush/stall/redir: got %b want 1110", name,
                     {bus.rf_wr_kill_o, bus.flush_o, bus.stall_o, bus.redirect_en_o});
        else pass_cnt++;
        @(posedge clk); #1;
        drive_wb(1'b0, 6'b0, 32'h0);
        bus.csr_wr_en_i = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (bus.redirect_en_o !== 1'b1 || bus.redirect_pc_o !== e.pc)
            $display("FAIL %s redirect: got en=%b pc=%h want en=1 pc=%h", name,
                     bus.redirect_en_o, bus.redirect_pc_o, e.pc);
        else pass_cnt++;
        total_cnt++;
        if ({bus.rf_wr_kill_o, bus.flush_o, bus.stall_o} !== 3'b011)
            $display("FAIL %s jump kill/flush/stall: got %b want 011", name,
                     {bus.rf_wr_kill_o, bus.flush_o, bus.stall_o});
        else pass_cnt++;
        total_cnt++;
        if (bus.mepc_o !== e.mepc || bus.mcause_o !== e.mcause || bus.mtval_o !== e.mtval ||
            bus.mstatus_mie_o !== e.mie || bus.mstatus_mpie_o !== e.mpie)
            $display("FAIL %s csrs: got mepc=%h mcause=%h mtval=%h mie=%b mpie=%b want %h %h %h %b %b",
                     name, bus.mepc_o, bus.mcause_o, bus.mtval_o, bus.mstatus_mie_o,
                     bus.mstatus_mpie_o, e.mepc, e.mcause, e.mtval, e.mie, e.mpie);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({bus.rf_wr_kill_o, bus.flush_o, bus.stall_o, bus.redirect_en_o} !== 4'b0 ||
            bus.redirect_pc_o !== 32'h0 || bus.mepc_o !== 32'h0 || bus.mcause_o !== 32'h0 ||
            bus.mtval_o !== 32'h0 || bus.mstatus_mie_o !== 1'b0 || bus.mstatus_mpie_o !== 1'b0)
            $display("FAIL reset_state: got strobes=%b rpc=%h mepc=%h mcause=%h mtval=%h mie=%b mpie=%b want all 0",
                     {bus.rf_wr_kill_o, bus.flush_o, bus.stall_o, bus.redirect_en_o},
                     bus.redirect_pc_o, bus.mepc_o, bus.mcause_o, bus.mtval_o,
                     bus.mstatus_mie_o, bus.mstatus_mpie_o);
        else pass_cnt++;
    endtask

    task automatic test_idle_instr();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive_wb(1'b1, 6'b0, 32'h1000 + 32'(i * 4));
            @(negedge clk);
            total_cnt++;
            if ({bus.rf_wr_kill_o, bus.flush_o, bus.stall_o, bus.redirect_en_o} !== 4'b0)
                $display("FAIL idle_instr%0d strobes: got %b want 0000", i,
                         {bus.rf_wr_kill_o, bus.flush_o, bus.stall_o, bus.redirect_en_o});
            else pass_cnt++;
        end
        @(posedge clk); #1;
        drive_wb(1'b0, 6'b0, 32'h0);
    endtask

    task automatic test_csr_writes();
        csr_write(12'h341, 32'h1234_5677);
        csr_write(12'h342, 32'hFFFF_FFFF);
        csr_write(12'h343, 32'hDEAD_BEEF);
        csr_write(12'h344, 32'hFFFF_FFFF);
        csr_write(12'h300, 32'h0000_0088);
        @(negedge clk);
        total_cnt++;
        if (bus.mepc_o !== 32'h1234_5674 || bus.mcause_o !== 32'h0000_000F ||
            bus.mtval_o !== 32'hDEAD_BEEF || bus.mstatus_mie_o !== 1'b1 || bus.mstatus_mpie_o !== 1'b1)
            $display("FAIL csr_writes: got mepc=%h mcause=%h mtval=%h mie=%b mpie=%b want 12345674 0000000f deadbeef 1 1",
                     bus.mepc_o, bus.mcause_o, bus.mtval_o, bus.mstatus_mie_o, bus.mstatus_mpie_o);
        else pass_cnt++;
    endtask

    task automatic test_ecall_mret();
        csr_write(12'h300, 32'h0000_0008);
        fire("ecall", F_ECALL, 32'h8000_0010);
        total_cnt++;
        if (bus.mcause_o !== 32'd11 || bus.mepc_o !== 32'h8000_0010 ||
            bus.mstatus_mie_o !== 1'b0 || bus.mstatus_mpie_o !== 1'b1)
            $display("FAIL ecall_abs: got mcause=%0d mepc=%h mie=%b mpie=%b want 11 80000010 0 1",
                     bus.mcause_o, bus.mepc_o, bus.mstatus_mie_o, bus.mstatus_mpie_o);
        else pass_cnt++;
        fire("mret", F_MRET, 32'h8000_0100);
        total_cnt++;
        if (bus.redirect_pc_o !== 32'h8000_0010 || bus.mstatus_mie_o !== 1'b1 ||
            bus.mstatus_mpie_o !== 1'b1)
            $display("FAIL mret_abs: got rpc=%h mie=%b mpie=%b want 80000010 1 1",
                     bus.redirect_pc_o, bus.mstatus_mie_o, bus.mstatus_mpie_o);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.redirect_en_o !== 1'b0 || bus.flush_o !== 1'b0)
            $display("FAIL redirect_single_pulse: got en=%b flush=%b want 0 0",
                     bus.redirect_en_o, bus.flush_o);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        fire("misalign_ecall", F_MISALIGN | F_ECALL, 32'h0000_0202);
        fire("buserr_ilgl", F_BUS_ERR | F_ILGL | F_MRET, 32'h0000_0308);
        fire("ilgl_ebreak", F_ILGL | F_EBREAK, 32'h0000_0404);
        fire("ebreak_ecall", F_EBREAK | F_ECALL | F_MRET, 32'h0000_0506);
    endtask

    task automatic test_trap_vs_csr();
        fire("trap_vs_csr", F_EBREAK, 32'h0000_0600, 1'b1, 12'h342, 32'd5);
        total_cnt++;
        if (bus.mcause_o !== 32'd3)
            $display("FAIL trap_vs_csr_mcause: got %0d want 3", bus.mcause_o);
        else pass_cnt++;
        @(posedge clk); #1;
        drive_wb(1'b0, F_ECALL, 32'h0000_0700);
        @(negedge clk);
        total_cnt++;
        if ({bus.rf_wr_kill_o, bus.flush_o, bus.stall_o} !== 3'b000)
            $display("FAIL invalid_flag_trigger: got %b want 000",
                     {bus.rf_wr_kill_o, bus.flush_o, bus.stall_o});
        else pass_cnt++;
        @(posedge clk); #1;
        drive_wb(1'b0, 6'b0, 32'h0);
        @(negedge clk);
        total_cnt++;
        if (bus.redirect_en_o !== 1'b0 || bus.mcause_o !== m_mcause)
            $display("FAIL invalid_flag_redirect: got en=%b mcause=%0d want 0 %0d",
                     bus.redirect_en_o, bus.mcause_o, m_mcause);
        else pass_cnt++;
    endtask

    task automatic test_mepc_write_mret();
        csr_write(12'h341, 32'h0000_4003);
        fire("mepc_wr_mret", F_MRET, 32'h0000_0800);
    endtask

    task automatic test_back_to_back();
        fire("b2b_first", F_ILGL, 32'h0000_0900);
        fire("b2b_second", F_BUS_ERR, 32'h0000_0A02);
        fire("b2b_third", F_MRET, 32'h0000_0B00);
    endtask

    task automatic test_reset_in_jump();
        @(posedge clk); #1;
        drive_wb(1'b1, F_ECALL, 32'h0000_0C00);
        @(posedge clk); #1;
        drive_wb(1'b0, 6'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.redirect_en_o !== 1'b0)
            $display("FAIL rst_in_jump_pulse: got en=%b want 0", bus.redirect_en_o);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total_cnt++;
        if ({bus.flush_o, bus.stall_o, bus.redirect_en_o} !== 3'b000 || bus.mepc_o !== 32'h0 ||
            bus.mcause_o !== 32'h0 || bus.mtval_o !== 32'h0 || bus.mstatus_mie_o !== 1'b0 ||
            bus.mstatus_mpie_o !== 1'b0 || bus.redirect_pc_o !== 32'h0)
            $display("FAIL rst_in_jump_state: got strobes=%b mepc=%h mcause=%h mtval=%h mie=%b mpie=%b rpc=%h want all 0",
                     {bus.flush_o, bus.stall_o, bus.redirect_en_o}, bus.mepc_o, bus.mcause_o,
                     bus.mtval_o, bus.mstatus_mie_o, bus.mstatus_mpie_o, bus.redirect_pc_o);
        else pass_cnt++;
        fire("after_rst", F_ECALL, 32'h0000_0D00);
    endtask

    initial begin
        drive_wb(1'b0, 6'b0, 32'h0);
        bus.mtvec_i       = MTVEC;
        bus.csr_wr_en_i   = 1'b0;
        bus.csr_wr_addr_i = 12'h0;
        bus.csr_wr_data_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_idle_instr();
        test_csr_writes();
        test_ecall_mret();
        test_priority();
        test_trap_vs_csr();
        test_mepc_write_mret();
        test_back_to_back();
        test_reset_in_jump();

        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
